// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - pipelined 32-bit system bus port (cyc/stb/we/addr/sel/data/ack/stall/err)
interface bus_arbiter_if;
   localparam int DataWidth = 32;
   localparam int AddrWidth = 32;
   localparam int SelWidth  = DataWidth / 8;

   logic                 cyc;
   logic                 stb;
   logic                 we;
   logic [AddrWidth-1:0] addr;
   logic [SelWidth-1:0]  sel;
   logic [DataWidth-1:0] data_m;
   logic [DataWidth-1:0] data_s;
   logic                 ack;
   logic                 err;
   logic                 stall;

   modport master (
      output cyc, stb, we, addr, sel, data_m,
      input  data_s, ack, err, stall
   );

   modport slave (
      input  cyc, stb, we, addr, sel, data_m,
      output data_s, ack, err, stall
   );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master one-slave bus arbiter with outstanding-transfer tracking
// Optional BUS_ARBITER_ROUND_ROBIN_EN: ties go to the master that was not granted last.
module bus_arbiter #(
   parameter int MaxOutstanding = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   bus_arbiter_if.slave  m0,
   bus_arbiter_if.slave  m1,
   bus_arbiter_if.master s
);
   localparam int CntW = $clog2(MaxOutstanding + 1);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] count_q, count_d;
   logic            last_q, last_d;
   logic            full;
   logic            accept;
   logic            resp;
   logic            tie_winner;
   logic            pick;

   assign full   = (count_q == CntW'(MaxOutstanding));
   assign accept = s.stb & ~s.stall;
   // Responses with nothing outstanding (e.g. stragglers after reset) are ignored.
   assign resp   = (s.ack | s.err) & (count_q != '0);

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
   assign tie_winner = ~last_q;
`else
   assign tie_winner = 1'b0;
`endif

   assign pick = (m0.cyc & m1.cyc) ? tie_winner : m1.cyc;

   always_comb begin
      count_d = count_q;
      if (accept && !resp && !full) begin
         count_d = count_q + CntW'(1);
      end else if (resp && !accept) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (m0.cyc || m1.cyc) begin
               state_d = pick ? GRANT1 : GRANT0;
               last_d  = pick;
            end
         end
         GRANT0: begin
            if (!m0.cyc) begin
               if (count_d != '0) begin
                  state_d = DRAIN;
               end else if (m1.cyc) begin
                  state_d = GRANT1;
                  last_d  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GRANT1: begin
            if (!m1.cyc) begin
               if (count_d != '0) begin
                  state_d = DRAIN;
               end else if (m0.cyc) begin
                  state_d = GRANT0;
                  last_d  = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DRAIN: begin
            if (count_d == '0) begin
               if (m0.cyc || m1.cyc) begin
                  state_d = pick ? GRANT1 : GRANT0;
                  last_d  = pick;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

   // Routing is purely a function of the registered grant.
   always_comb begin
      s.cyc     = 1'b0;
      s.stb     = 1'b0;
      s.we      = 1'b0;
      s.addr    = '0;
      s.sel     = '0;
      s.data_m  = '0;
      m0.data_s = '0;
      m0.ack    = 1'b0;
      m0.err    = 1'b0;
      m0.stall  = 1'b1;
      m1.data_s = '0;
      m1.ack    = 1'b0;
      m1.err    = 1'b0;
      m1.stall  = 1'b1;
      case (state_q)
         GRANT0: begin
            s.cyc     = m0.cyc;
            s.stb     = m0.stb & ~full;
            s.we      = m0.we;
            s.addr    = m0.addr;
            s.sel     = m0.sel;
            s.data_m  = m0.data_m;
            m0.stall  = s.stall | full;
            m0.ack    = s.ack;
            m0.err    = s.err;
            m0.data_s = s.data_s;
         end
         GRANT1: begin
            s.cyc     = m1.cyc;
            s.stb     = m1.stb & ~full;
            s.we      = m1.we;
            s.addr    = m1.addr;
            s.sel     = m1.sel;
            s.data_m  = m1.data_m;
            m1.stall  = s.stall | full;
            m1.ack    = s.ack;
            m1.err    = s.err;
            m1.data_s = s.data_s;
         end
         DRAIN: begin
            s.cyc = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   bus_arbiter_if m0_if ();
   bus_arbiter_if m1_if ();
   bus_arbiter_if s_if ();

   bus_arbiter #(.MaxOutstanding(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .m0    (m0_if),
      .m1    (m1_if),
      .s     (s_if)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      m0_if.cyc    = 1'b1;  m0_if.stb = 1'b0;  m0_if.we = 1'b0;
      m0_if.addr   = '0;    m0_if.sel = '0;    m0_if.data_m = 32'h0000_00A0;
      m1_if.cyc    = 1'b1;  m1_if.stb = 1'b0;  m1_if.we = 1'b1;
      m1_if.addr   = '0;    m1_if.sel = '0;    m1_if.data_m = 32'h0000_00B1;
      s_if.data_s  = 32'hDEAD_BEEF;
      s_if.ack     = 1'b1;
      s_if.err     = 1'b0;
      s_if.stall   = 1'b0;

      // Reset with both masters requesting
      tick(); tick(); settle();
      chk("rst_m0_stall", 32'(m0_if.stall), 32'd1);
      chk("rst_m1_stall", 32'(m1_if.stall), 32'd1);
      chk("rst_s_cyc",    32'(s_if.cyc),    32'd0);
      chk("rst_s_stb",    32'(s_if.stb),    32'd0);
      chk("rst_m0_ack",   32'(m0_if.ack),   32'd0);
      chk("rst_m0_data",  m0_if.data_s,     32'd0);
      chk("rst_s_addr",   s_if.addr,        32'd0);
      chk("rst_count",    32'(dut.count_q), 32'd0);

      // Cycle N: first request seen in IDLE
      tick();
      rst_n = 1'b1; s_if.ack = 1'b0;
      m0_if.stb = 1'b1; m0_if.addr = 32'h10; m0_if.sel = 4'hF;
      m1_if.stb = 1'b1; m1_if.addr = 32'h20; m1_if.sel = 4'h3;
      settle();
      chk("n_m0_stall", 32'(m0_if.stall), 32'd1);
      chk("n_s_stb",    32'(s_if.stb),    32'd0);

      // N+1: master 0 wins the first tie
      tick(); settle();
      chk("g0_s_stb",    32'(s_if.stb),    32'd1);
      chk("g0_s_addr",   s_if.addr,        32'h10);
      chk("g0_s_sel",    32'(s_if.sel),    32'hF);
      chk("g0_m0_stall", 32'(m0_if.stall), 32'd0);
      chk("g0_m1_stall", 32'(m1_if.stall), 32'd1);

      // N+2: one-cycle slave acks
      tick();
      m0_if.stb = 1'b0; s_if.ack = 1'b1; s_if.data_s = 32'hCAFE_0010;
      settle();
      chk("rd_m0_ack",  32'(m0_if.ack),   32'd1);
      chk("rd_m0_data", m0_if.data_s,     32'hCAFE_0010);
      chk("rd_m1_ack",  32'(m1_if.ack),   32'd0);
      chk("rd_m1_data", m1_if.data_s,     32'd0);

      tick();
      s_if.ack = 1'b0; m0_if.stb = 1'b1; m0_if.addr = 32'h100;
      settle();
      chk("rd_count0", 32'(dut.count_q), 32'd0);

      // Saturation: four accepted without acks
      for (int i = 0; i < 4; i++) begin
         chk("sat_count", 32'(dut.count_q), 32'(i));
         chk("sat_s_stb", 32'(s_if.stb),    32'd1);
         tick(); settle();
      end
      chk("sat_full_count", 32'(dut.count_q), 32'd4);
      chk("sat_full_stall", 32'(m0_if.stall), 32'd1);
      chk("sat_full_stb",   32'(s_if.stb),    32'd0);
      tick(); settle();
      chk("sat_hold_stall", 32'(m0_if.stall), 32'd1);
      s_if.ack = 1'b1;
      settle();
      chk("sat_ack_stall", 32'(m0_if.stall), 32'd1);
      tick();
      s_if.ack = 1'b0;
      settle();
      chk("sat_rel_count", 32'(dut.count_q), 32'd3);
      chk("sat_rel_stall", 32'(m0_if.stall), 32'd0);
      chk("sat_rel_stb",   32'(s_if.stb),    32'd1);
      tick(); settle();
      chk("sat_one_count", 32'(dut.count_q), 32'd4);
      chk("sat_one_stall", 32'(m0_if.stall), 32'd1);

      // Simultaneous accept and ack at count 2
      m0_if.stb = 1'b0; s_if.ack = 1'b1;
      tick(); tick();
      m0_if.stb = 1'b1;
      settle();
      chk("sim_pre_count", 32'(dut.count_q), 32'd2);
      chk("sim_pre_stb",   32'(s_if.stb),    32'd1);
      tick();
      m0_if.stb = 1'b0;
      settle();
      chk("sim_count", 32'(dut.count_q), 32'd2);
      tick(); tick();
      s_if.ack = 1'b0;
      settle();
      chk("sim_empty", 32'(dut.count_q), 32'd0);

      // Back-to-back handover to waiting master 1
      m0_if.cyc = 1'b0;
      tick(); settle();
      chk("ho_s_addr",   s_if.addr,        32'h20);
      chk("ho_m1_stall", 32'(m1_if.stall), 32'd0);
      chk("ho_m0_stall", 32'(m0_if.stall), 32'd1);
      chk("ho_s_stb",    32'(s_if.stb),    32'd1);
      tick(); settle();
      chk("ho_count1", 32'(dut.count_q), 32'd1);

      // Master 1 abandons two outstanding transfers
      tick();
      m1_if.stb = 1'b0; m1_if.cyc = 1'b0;
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.addr = 32'h30;
      settle();
      chk("dr_count2", 32'(dut.count_q), 32'd2);
      tick(); settle();
      chk("dr_s_cyc",    32'(s_if.cyc),    32'd1);
      chk("dr_s_stb",    32'(s_if.stb),    32'd0);
      chk("dr_m0_stall", 32'(m0_if.stall), 32'd1);
      chk("dr_m1_stall", 32'(m1_if.stall), 32'd1);
      s_if.ack = 1'b1;
      settle();
      chk("dr_m1_ack_a", 32'(m1_if.ack), 32'd0);
      chk("dr_m0_ack_a", 32'(m0_if.ack), 32'd0);
      tick(); settle();
      chk("dr_count1",   32'(dut.count_q), 32'd1);
      chk("dr_m1_ack_b", 32'(m1_if.ack),   32'd0);
      chk("dr_m0_ack_b", 32'(m0_if.ack),   32'd0);
      tick();
      s_if.ack = 1'b0;
      settle();
      chk("dr_exit_addr",  s_if.addr,        32'h30);
      chk("dr_exit_stall", 32'(m0_if.stall), 32'd0);
      chk("dr_exit_stb",   32'(s_if.stb),    32'd1);

      // Error response on master 1's transfer
      tick();
      m0_if.stb = 1'b0; s_if.ack = 1'b1;
      settle();
      tick();
      s_if.ack = 1'b0; m0_if.cyc = 1'b0;
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.addr = 32'h40;
      settle();
      chk("err_pre_count", 32'(dut.count_q), 32'd0);
      tick(); settle();
      chk("err_grant_addr", s_if.addr, 32'h40);
      tick();
      m1_if.stb = 1'b0; s_if.err = 1'b1;
      settle();
      chk("err_m1_err",   32'(m1_if.err),   32'd1);
      chk("err_m0_err",   32'(m0_if.err),   32'd0);
      chk("err_m1_ack",   32'(m1_if.ack),   32'd0);
      chk("err_count1",   32'(dut.count_q), 32'd1);
      tick();
      s_if.err = 1'b0; m1_if.cyc = 1'b0;
      settle();
      chk("err_m1_clear", 32'(m1_if.err),   32'd0);
      chk("err_count0",   32'(dut.count_q), 32'd0);

      // Tie after master 0 was granted last
      tick(); settle();
      chk("idle_s_cyc", 32'(s_if.cyc), 32'd0);
      m0_if.cyc = 1'b1;
      tick();
      m0_if.cyc = 1'b0;
      settle();
      tick();
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.addr = 32'h50;
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.addr = 32'h60;
      settle();
      tick(); settle();
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      chk("tie_winner", s_if.addr, 32'h60);
`else
      chk("tie_winner", s_if.addr, 32'h50);
`endif

      // Reset in the middle of a transfer
      tick();
      rst_n = 1'b0;
      settle();
      tick();
      rst_n = 1'b1;
      m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
      m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
      s_if.ack = 1'b1;
      settle();
      chk("rm_s_cyc",  32'(s_if.cyc),     32'd0);
      chk("rm_m0_ack", 32'(m0_if.ack),    32'd0);
      chk("rm_m1_ack", 32'(m1_if.ack),    32'd0);
      chk("rm_count",  32'(dut.count_q),  32'd0);
      tick();
      s_if.ack = 1'b0;
      settle();
      chk("rm_count_after", 32'(dut.count_q), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
